// File: rtl/mem_pipelined.sv
// Tagged fixed-latency memory model: one command per cycle, up to NUM_TAGS loads
// in flight, each load answered exactly LATENCY cycles after acceptance, in order.
module mem_pipelined #(
  parameter int LINES    = 8192,
  parameter int LATENCY  = 4,
  parameter int NUM_TAGS = 15,
  parameter int TAG_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        proc2mem_command,
  input  logic [31:0]       proc2mem_addr,
  input  logic [63:0]       proc2mem_data,
  output logic [TAG_W-1:0]  mem2proc_transaction_tag,
  output logic [63:0]       mem2proc_data,
  output logic [TAG_W-1:0]  mem2proc_data_tag,
  output logic              busy,
  output logic              addr_err,
  output logic [31:0]       load_count,
  output logic [31:0]       store_count
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } resp_t;

  // Contents are deliberately outside the reset domain so benches can preload them.
  logic [63:0] unified_memory [LINES];

  resp_t               pipe_q [LATENCY];
  resp_t               pipe_d [LATENCY];
  logic [NUM_TAGS-1:0] used_q, used_d;
  logic                busy_q, busy_d;
  logic                addr_err_q, addr_err_d;
  logic [31:0]         load_count_q, load_count_d;
  logic [31:0]         store_count_q, store_count_d;

  logic             in_range, is_load, is_store, load_ok, store_ok;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] alloc_tag;
  resp_t            head;

  always_comb begin
    in_range = (proc2mem_addr[2:0] == 3'b000) &&
               ({3'b000, proc2mem_addr[31:3]} < 32'(LINES));
    idx      = proc2mem_addr[3 +: IDX_W];
    is_load  = !reset && (proc2mem_command == CMD_LOAD);
    is_store = !reset && (proc2mem_command == CMD_STORE);

    // Scan downwards so the last hit is the lowest-numbered free tag.
    alloc_tag = '0;
    for (int t = NUM_TAGS; t >= 1; t--) begin
      if (!used_q[t-1]) alloc_tag = TAG_W'(t);
    end
    if (!(is_load && in_range)) alloc_tag = '0;

    load_ok  = (alloc_tag != '0);
    store_ok = is_store && in_range;
    head     = pipe_q[LATENCY-1];

    pipe_d[0].tag  = alloc_tag;
    pipe_d[0].data = load_ok ? unified_memory[idx] : 64'd0;
    for (int k = 1; k < LATENCY; k++) pipe_d[k] = pipe_q[k-1];

    // Release of the head tag and a new allocation never collide: the head
    // tag is still marked used this cycle, so the allocator cannot pick it.
    used_d = used_q;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (head.tag == TAG_W'(t + 1)) used_d[t] = 1'b0;
      if (alloc_tag == TAG_W'(t + 1)) used_d[t] = 1'b1;
    end
    busy_d = |used_d;

    addr_err_d    = addr_err_q | ((is_load | is_store) & ~in_range);
    load_count_d  = load_count_q + (load_ok ? 32'd1 : 32'd0);
    store_count_d = store_count_q + (store_ok ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) pipe_q[k] <= '0;
      used_q        <= '0;
      busy_q        <= 1'b0;
      addr_err_q    <= 1'b0;
      load_count_q  <= '0;
      store_count_q <= '0;
    end else begin
      for (int k = 0; k < LATENCY; k++) pipe_q[k] <= pipe_d[k];
      used_q        <= used_d;
      busy_q        <= busy_d;
      addr_err_q    <= addr_err_d;
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (store_ok) unified_memory[idx] <= proc2mem_data;
  end

  assign mem2proc_transaction_tag = alloc_tag;
  assign mem2proc_data            = head.data;
  assign mem2proc_data_tag        = head.tag;
  assign busy                     = busy_q;
  assign addr_err                 = addr_err_q;
  assign load_count               = load_count_q;
  assign store_count              = store_count_q;

endmodule

// File: tb/tb_mem_pipelined.sv
// Scoreboard bench for mem_pipelined: instance A uses defaults, instance B is a
// small config (LINES=16, NUM_TAGS=2) for tag exhaustion and address checks.
module tb_mem_pipelined;

  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, rst_b;
  logic [1:0]  cmd_a, cmd_b;
  logic [31:0] addr_a, addr_b;
  logic [63:0] wdata_a, wdata_b, rdata_a, rdata_b;
  logic [3:0]  ttag_a, ttag_b, rtag_a, rtag_b;
  logic        busy_a, busy_b, err_a, err_b;
  logic [31:0] lc_a, lc_b, sc_a, sc_b;

  mem_pipelined u_a (
    .clock(clock), .reset(rst_a), .proc2mem_command(cmd_a), .proc2mem_addr(addr_a),
    .proc2mem_data(wdata_a), .mem2proc_transaction_tag(ttag_a), .mem2proc_data(rdata_a),
    .mem2proc_data_tag(rtag_a), .busy(busy_a), .addr_err(err_a),
    .load_count(lc_a), .store_count(sc_a)
  );

  mem_pipelined #(.LINES(16), .LATENCY(4), .NUM_TAGS(2), .TAG_W(4)) u_b (
    .clock(clock), .reset(rst_b), .proc2mem_command(cmd_b), .proc2mem_addr(addr_b),
    .proc2mem_data(wdata_b), .mem2proc_transaction_tag(ttag_b), .mem2proc_data(rdata_b),
    .mem2proc_data_tag(rtag_b), .busy(busy_b), .addr_err(err_b),
    .load_count(lc_b), .store_count(sc_b)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Response monitor: the scoreboard head must appear exactly on its due cycle,
  // and nothing may appear otherwise.
  task automatic mon(input bit sel, input logic [3:0] tag, input logic [63:0] data);
    exp_t e;
    bit   have;
    have = sel ? (sb_b.size() > 0) : (sb_a.size() > 0);
    if (have) e = sel ? sb_b[0] : sb_a[0];
    if (have && e.due == cyc) begin
      if (sel) void'(sb_b.pop_front()); else void'(sb_a.pop_front());
      check(sel ? "resp_tag_b" : "resp_tag_a", 64'(tag), 64'(e.tag));
      check(sel ? "resp_data_b" : "resp_data_a", data, e.data);
    end else if (tag != 4'd0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_resp_%s @cyc %0d: got tag %0d expected none",
               sel ? "b" : "a", cyc, tag);
    end
  endtask

  always @(negedge clock) begin
    mon(1'b0, rtag_a, rdata_a);
    mon(1'b1, rtag_b, rdata_b);
  end

  task automatic issue(input bit sel, input logic [1:0] c, input logic [31:0] a,
                       input logic [63:0] d, input logic [3:0] etag, input logic [63:0] edata);
    exp_t e;
    if (sel) begin cmd_b = c; addr_b = a; wdata_b = d; end
    else     begin cmd_a = c; addr_a = a; wdata_a = d; end
    #1;
    check(sel ? "txn_tag_b" : "txn_tag_a", 64'(sel ? ttag_b : ttag_a), 64'(etag));
    if (etag != 4'd0) begin
      e.due = cyc + 4; e.tag = etag; e.data = edata;
      if (sel) sb_b.push_back(e); else sb_a.push_back(e);
    end
    @(posedge clock); #1;
    if (sel) cmd_b = NONE; else cmd_a = NONE;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    cmd_a = NONE; addr_a = '0; wdata_a = '0;
    cmd_b = NONE; addr_b = '0; wdata_b = '0;
    repeat (2) @(posedge clock);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    check("rst_data_tag", 64'(rtag_a), 64'd0);
    check("rst_data", rdata_a, 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_addr_err", 64'(err_a), 64'd0);
    check("rst_load_count", 64'(lc_a), 64'd0);
    check("rst_store_count", 64'(sc_a), 64'd0);

    // Preload through stores; no tag for stores.
    issue(0, STORE, 32'h10, 64'hDEADBEEF_00000001, 0, 0);
    issue(0, STORE, 32'h00, 64'hA0, 0, 0);
    issue(0, STORE, 32'h08, 64'hA1, 0, 0);
    issue(0, STORE, 32'h18, 64'hA3, 0, 0);
    issue(0, STORE, 32'h28, 64'h66, 0, 0);
    check("store_count_pre", 64'(sc_a), 64'd5);

    // Single load.
    issue(0, LOAD, 32'h10, 0, 4'd1, 64'hDEADBEEF_00000001);
    idle(5);
    check("load_count_single", 64'(lc_a), 64'd1);
    check("busy_after_single", 64'(busy_a), 64'd0);

    // Back-to-back.
    issue(0, LOAD, 32'h00, 0, 4'd1, 64'hA0);
    issue(0, LOAD, 32'h08, 0, 4'd2, 64'hA1);
    issue(0, LOAD, 32'h10, 0, 4'd3, 64'hDEADBEEF_00000001);
    issue(0, LOAD, 32'h18, 0, 4'd4, 64'hA3);
    idle(3);
    check("busy_last_resp", 64'(busy_a), 64'd1);
    idle(1);
    check("busy_fall", 64'(busy_a), 64'd0);

    // Store/load ordering.
    issue(0, STORE, 32'h20, 64'h55, 0, 0);
    issue(0, LOAD, 32'h20, 0, 4'd1, 64'h55);
    issue(0, LOAD, 32'h28, 0, 4'd2, 64'h66);
    issue(0, STORE, 32'h28, 64'h77, 0, 0);
    issue(0, LOAD, 32'h28, 0, 4'd3, 64'h77);
    idle(6);
    check("load_count_a", 64'(lc_a), 64'd8);
    check("store_count_a", 64'(sc_a), 64'd7);

    // Tag exhaustion on the 2-tag instance.
    issue(1, STORE, 32'h00, 64'hB0, 0, 0);
    issue(1, STORE, 32'h08, 64'hB1, 0, 0);
    issue(1, LOAD, 32'h00, 0, 4'd1, 64'hB0);
    issue(1, LOAD, 32'h00, 0, 4'd2, 64'hB0);
    for (int i = 0; i < 3; i++) issue(1, LOAD, 32'h00, 0, 4'd0, 0);
    issue(1, LOAD, 32'h00, 0, 4'd1, 64'hB0);
    issue(1, LOAD, 32'h00, 0, 4'd2, 64'hB0);
    idle(6);
    check("load_count_exh", 64'(lc_b), 64'd4);

    // Out of range and misaligned commands.
    check("addr_err_before", 64'(err_b), 64'd0);
    issue(1, LOAD, 32'h80, 0, 4'd0, 0);
    check("addr_err_rise", 64'(err_b), 64'd1);
    issue(1, STORE, 32'h84, 64'hBAD0, 0, 0);
    issue(1, STORE, 32'h09, 64'hBAD1, 0, 0);
    issue(1, LOAD, 32'h08, 0, 4'd1, 64'hB1);
    issue(1, LOAD, 32'h00, 0, 4'd2, 64'hB0);
    idle(6);
    issue(1, STORE, 32'h78, 64'hBF, 0, 0);
    issue(1, LOAD, 32'h78, 0, 4'd1, 64'hBF);
    idle(6);
    check("addr_err_held", 64'(err_b), 64'd1);
    check("store_count_oor", 64'(sc_b), 64'd3);
    check("load_count_oor", 64'(lc_b), 64'd7);

    // Reset mid-flight: in-flight loads are dropped.
    issue(0, LOAD, 32'h00, 0, 4'd1, 64'hA0);
    issue(0, LOAD, 32'h08, 0, 4'd2, 64'hA1);
    issue(0, LOAD, 32'h10, 0, 4'd3, 64'hDEADBEEF_00000001);
    rst_a = 1'b1; cmd_a = LOAD; addr_a = 32'h00;
    sb_a.delete();
    #1;
    check("txn_tag_in_reset", 64'(ttag_a), 64'd0);
    @(posedge clock); #1;
    rst_a = 1'b0; cmd_a = NONE;
    check("post_rst_busy", 64'(busy_a), 64'd0);
    check("post_rst_load_count", 64'(lc_a), 64'd0);
    check("post_rst_store_count", 64'(sc_a), 64'd0);
    issue(0, LOAD, 32'h10, 0, 4'd1, 64'hDEADBEEF_00000001);
    idle(6);
    check("post_rst_load_count2", 64'(lc_a), 64'd1);

    check("sb_a_empty", 64'(sb_a.size()), 64'd0);
    check("sb_b_empty", 64'(sb_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_pipelined.md
# mem_pipelined

Parametrised, tagged, fixed-latency memory model that replaces the single-outstanding `mem` in the bitNN bench and in unit benches for the fetch and writeback units. It accepts one command per cycle and keeps up to `NUM_TAGS` loads in flight. Each load returns its data exactly `LATENCY` cycles after acceptance, in order. Contents live in `unified_memory`, which benches load by hierarchical `$readmemh`; reset never clears it.

## Interface
- `LINES`, 8192: number of 64-bit lines in `unified_memory`.
- `LATENCY`, 4: cycles from load acceptance to data return; legal range 1..32.
- `NUM_TAGS`, 15: maximum loads in flight; tags are 1..`NUM_TAGS`; 0 is reserved.
- `TAG_W`, 4: tag width; must satisfy 2^`TAG_W` > `NUM_TAGS`.
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `proc2mem_command` in 2: command; NONE=0, LOAD=1, STORE=2, 3 is treated as NONE.
- `proc2mem_addr` in 32: byte address.
- `proc2mem_data` in 64: store data.
- `mem2proc_transaction_tag` out `TAG_W`: combinational; tag allocated to the current LOAD, 0 otherwise.
- `mem2proc_data` out 64: registered load data.
- `mem2proc_data_tag` out `TAG_W`: registered; tag of the returning load, 0 when there is no response.
- `busy` out 1: registered; 1 when any tag is in use.
- `addr_err` out 1: registered, sticky; set by any out-of-range or misaligned command.
- `load_count` out 32: registered count of accepted loads.
- `store_count` out 32: registered count of accepted stores.

## Operation
- **Address check.** A command is in range when `addr[2:0]==0` and `addr>>3 < LINES`.
  - A LOAD or STORE that fails the check is ignored: no write, no tag, no counter change.
  - On the next edge such a command sets `addr_err`, which stays set until reset.
- **Tag allocator.** A free mask of `NUM_TAGS` bits.
  - `mem2proc_transaction_tag` is the lowest-numbered free tag when the command is an in-range LOAD.
  - It is 0 when the command is NONE, STORE, or out of range, or when no tag is free (load rejected; requester retries).
- **Load acceptance** (nonzero tag at the edge):
  - `unified_memory[addr>>3]` is read at that edge.
  - `{tag, data}` is pushed into a `LATENCY`-deep shift pipeline.
  - The tag is marked busy.
  - `load_count` increments.
- **Store acceptance.** Every in-range STORE is accepted; stores never stall.
  - `unified_memory[addr>>3]` is written at that edge.
  - `mem2proc_transaction_tag` is 0.
  - `store_count` increments.
  - No response is generated.
- **Response.** The pipeline head drives `mem2proc_data` and `mem2proc_data_tag` for exactly one cycle. Empty slots drive tag 0 and data 0.
- **Ordering.** Responses come out in acceptance order, with at most one per cycle. Data reflects memory at the acceptance edge: a later store to the same line does not alter an in-flight load.
- **Tag release.** A tag is freed on the edge that ends its response cycle. A release and an allocation of the same tag in the same cycle are not possible; the freed tag becomes allocatable in the next cycle.
- **Throughput.** Sustained 1 load per cycle requires `NUM_TAGS` ≥ `LATENCY`+1. Otherwise loads are rejected cyclically.
- **Counters** wrap modulo 2^32.
- **Reset** (synchronous):
  - Pipeline cleared and all tags freed.
  - `mem2proc_data`, `mem2proc_data_tag`, `busy`, `addr_err`, `load_count` and `store_count` all reset to 0.
  - In-flight loads are dropped and never respond.
  - `unified_memory` is untouched.
  - Commands present while reset is high are ignored, and `mem2proc_transaction_tag` is forced to 0.

## Timing
- Cycle N: LOAD presented; `mem2proc_transaction_tag` is valid combinationally in N. Acceptance happens at the end-of-N edge.
- Cycle N+`LATENCY`: `mem2proc_data` and `mem2proc_data_tag` are valid.
- Cycle N+`LATENCY`+1: the tag is reusable.
- STORE presented in cycle N: the write is visible to a LOAD presented in cycle N+1.
- `busy` falls in the cycle after the last response.
- `addr_err` rises in the cycle after the offending command.

## Test plan
- **Single load.** Defaults; `mem[0x10>>3]=0xDEADBEEF_00000001`; LOAD 0x10 in cycle 0.
  - Tag 1 in cycle 0.
  - Cycle 4: data_tag=1, data=0xDEADBEEF_00000001.
  - Cycle 5: data_tag=0.
  - `load_count`=1.
- **Back-to-back.** LOADs to 0x0, 0x8, 0x10, 0x18 in cycles 0..3.
  - Tags 1, 2, 3, 4.
  - Responses in cycles 4..7 with matching tags and data.
  - `busy` 0 from cycle 8.
- **Exhaustion.** `NUM_TAGS`=2, `LATENCY`=4; LOAD every cycle from cycle 0.
  - Tags 1, 2, then 0 in cycles 2..4.
  - Tag 1 is reissued in cycle 5.
  - Responses only for accepted loads.
- **Store/load ordering.**
  - STORE 0x20=0x55 in cycle 0; LOAD 0x20 in cycle 1 returns 0x55 in cycle 5.
  - LOAD 0x28 in cycle 6, then STORE 0x28=0x77 in cycle 7; the load returns the old value.
- **Out of range.** `LINES`=16; LOAD 0x80 and STORE 0x84.
  - Tag 0, no memory change, counters unchanged.
  - `addr_err`=1 from the next cycle and held.
- **Reset mid-flight.** LOADs in cycles 0..2; reset high in cycle 3.
  - No response ever appears.
  - After reset: `busy`=0, counters 0, and the next LOAD receives tag 1.
  - Memory contents are preserved.
